// File: rtl/t03_nes_poller_if.sv
// ----------------------------------------------------------------------------
// t03_nes_poller_if
//   Bundle between the NES poller and its neighbours: the two raw controller
//   data lines coming from the gpio pads, the latch/pulse pad drives, and the
//   packed button word with its confirm strobe going to the MMIO block.
//
//   Handshake: confirm is a valid-only strobe with no ready. It is high for
//   exactly one clk cycle when packed_out has just been refreshed; packed_out
//   is stable from that cycle until the next confirm, so the consumer may
//   sample packed_out on the strobe cycle or at any time afterwards.
//
//   Signals
//     player_1_in  raw serial data, controller 1 (active-low, asynchronous)
//     player_2_in  raw serial data, controller 2 (active-low, asynchronous)
//     latch        controller latch pad drive
//     pulse        controller shift-clock pad drive
//     packed_out   {16'b0, p2[7:0], p1[7:0]}, 1 = pressed
//     confirm      1-cycle strobe, packed_out updated
//     busy         frame in progress
//     dbg_state    poller FSM state, for observation only
//
//   Modports: master = poller side, slave = pad/MMIO side.
// ----------------------------------------------------------------------------
interface t03_nes_poller_if;
    logic        player_1_in;
    logic        player_2_in;
    logic        latch;
    logic        pulse;
    logic [31:0] packed_out;
    logic        confirm;
    logic        busy;
    logic [2:0]  dbg_state;

    modport master (
        input  player_1_in, player_2_in,
        output latch, pulse, packed_out, confirm, busy, dbg_state
    );

    modport slave (
        output player_1_in, player_2_in,
        input  latch, pulse, packed_out, confirm, busy, dbg_state
    );
endinterface

// File: rtl/t03_nes_poller.sv
// ----------------------------------------------------------------------------
// t03_nes_poller
//   Autonomous dual NES-controller poller. A free-running poll counter starts
//   a frame every POLL_CYCLES clocks (if idle). A frame drives latch, then
//   seven pulse periods, sampling both serial lines (through 2-flop
//   synchronizers, inverted so that 1 = pressed) once after the latch gap
//   and once at the end of every pulse-low half. The 16-bit result is
//   published on packed_out with a one-cycle confirm strobe.
//
//   Ports
//     clk   in  system clock
//     rst   in  asynchronous active-high reset (aborts a frame immediately)
//     nes   t03_nes_poller_if.master (player lines in; latch, pulse,
//           packed_out, confirm, busy, dbg_state out)
//
//   Parameters
//     LATCH_CYCLES  latch high time in clk cycles
//     HALF_CYCLES   pulse half-period and latch-to-first-sample gap
//     POLL_CYCLES   poll period in clk cycles
//
//   Optional feature macro: T03_NES_DEBOUNCE_EN
//     Defined: a packed_out bit only changes when this frame's raw sample and
//     the previous frame's raw sample agree. Undefined: packed_out takes the
//     raw frame every time.
// ----------------------------------------------------------------------------
module t03_nes_poller #(
    parameter int LATCH_CYCLES = 120,
    parameter int HALF_CYCLES  = 60,
    parameter int POLL_CYCLES  = 166667
) (
    input  logic              clk,
    input  logic              rst,
    t03_nes_poller_if.master  nes
);

    localparam int PW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int CMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_PHI   = 3'd3;
    localparam logic [2:0] S_PLO   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [PW-1:0] poll_q, poll_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    sync1_q, sync2_q;
    logic [7:0]    sh1_q, sh2_q;
    logic          latch_q, latch_d;
    logic          pulse_q, pulse_d;
    logic          confirm_q;
    logic [15:0]   packed_q;
    logic [15:0]   raw_frame;
    logic [15:0]   packed_next;
    logic          tick;
    logic          sample;
    logic          half_end;

    assign tick      = (poll_q == PW'(POLL_CYCLES - 1));
    assign poll_d    = tick ? '0 : poll_q + PW'(1);
    assign half_end  = (cnt_q == CW'(HALF_CYCLES - 1));
    assign raw_frame = {sh2_q, sh1_q};

    // bit_q is the index the next sample lands in; a sample in GAP fills
    // bit 0, each later PLO sample fills the following bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        latch_d = 1'b0;
        pulse_d = 1'b0;
        sample  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    latch_d = 1'b1;
                end
            end
            S_LATCH: begin
                if (cnt_q == CW'(LATCH_CYCLES - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    latch_d = 1'b1;
                end
            end
            S_GAP, S_PLO: begin
                if (half_end) begin
                    sample = 1'b1;
                    bit_d  = bit_q + 3'd1;
                    cnt_d  = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PHI;
                        pulse_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PHI: begin
                if (half_end) begin
                    state_d = S_PLO;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    pulse_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef T03_NES_DEBOUNCE_EN
    // Previous frame's raw samples; a bit only moves when two frames agree.
    logic [15:0] prev_q;
    logic [15:0] agree;

    assign agree       = ~(raw_frame ^ prev_q);
    assign packed_next = (raw_frame & agree) | (packed_q & ~agree);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else if (state_q == S_DONE) begin
            prev_q <= raw_frame;
        end
    end
`else
    assign packed_next = raw_frame;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_q    <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            sh1_q     <= '0;
            sh2_q     <= '0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            confirm_q <= 1'b0;
            packed_q  <= '0;
        end else begin
            poll_q    <= poll_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sync1_q   <= {nes.player_2_in, nes.player_1_in};
            sync2_q   <= sync1_q;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            confirm_q <= (state_q == S_DONE);
            // Lines are active-low: a low line means the button is pressed.
            if (sample) begin
                sh1_q[bit_q] <= ~sync2_q[0];
                sh2_q[bit_q] <= ~sync2_q[1];
            end
            if (state_q == S_DONE) begin
                packed_q <= packed_next;
            end
        end
    end

    assign nes.latch      = latch_q;
    assign nes.pulse      = pulse_q;
    assign nes.confirm    = confirm_q;
    assign nes.busy       = (state_q != S_IDLE);
    assign nes.packed_out = {16'h0000, packed_q};
    assign nes.dbg_state  = state_q;

endmodule

// File: tb/tb_t03_nes_poller.sv
module tb_t03_nes_poller;

  logic clk;
  logic rst;
  logic line1;
  logic line2;

  t03_nes_poller_if if_a();
  t03_nes_poller_if if_b();

  assign if_a.player_1_in = line1;
  assign if_a.player_2_in = line2;
  assign if_b.player_1_in = line1;
  assign if_b.player_2_in = line2;

  // dut_a: normal poll period; dut_b: poll period shorter than a frame.
  t03_nes_poller #(.LATCH_CYCLES(4), .HALF_CYCLES(2), .POLL_CYCLES(100)) dut_a (
    .clk(clk), .rst(rst), .nes(if_a.master)
  );
  t03_nes_poller #(.LATCH_CYCLES(4), .HALF_CYCLES(2), .POLL_CYCLES(30)) dut_b (
    .clk(clk), .rst(rst), .nes(if_b.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model state ----------------
  // Frame timing in edges after the tick edge: latch 0..3, gap 4..5,
  // pulse high at 6+4k..7+4k, bit i sampled at edge 6+4i from the line
  // value seen two edges earlier, packed/confirm at 35, busy 0..34.
  localparam int FRAME_LEN = 35;
  localparam int NO_FRAME  = -1000;

  int vectors;
  int miscompares;
  int cyc;
  logic hist1 [0:8191];
  logic hist2 [0:8191];
  int start_c [2];
  logic [31:0] exp_pk [2];
  logic [15:0] prev_raw [2];
  int exp_conf_total [2];
  int obs_conf_total [2];
  int overlap_n;

  // stimulus
  int mode;  // 0 idle-high, 1 controller, 2 random, 3 edge-of-sample
  logic [7:0] btn1;
  logic [7:0] btn2;
  int cidx;
  logic pulse_seen;

  // per-segment observations of dut_a
  int lat_n, pul_n, rise_n, conf_at, first_latch;
  logic pulse_prev_a;

  // ---------------- scoreboard helpers ----------------
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      start_c[u]  = NO_FRAME;
      exp_pk[u]   = 32'h0;
      prev_raw[u] = 16'h0;
    end
  endtask

  task automatic model_edge(input int u, input int per);
    int d;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [15:0] raw;
`ifdef T03_NES_DEBOUNCE_EN
    logic [15:0] agree;
`endif
    if ((cyc % per) == 0 && (cyc - start_c[u]) > FRAME_LEN) start_c[u] = cyc;
    d = cyc - start_c[u];
    if (d == FRAME_LEN) begin
      for (int i = 0; i < 8; i++) begin
        r1[i] = ~hist1[start_c[u] + 4 + 4 * i];
        r2[i] = ~hist2[start_c[u] + 4 + 4 * i];
      end
      raw = {r2, r1};
`ifdef T03_NES_DEBOUNCE_EN
      agree = ~(raw ^ prev_raw[u]);
      exp_pk[u] = {16'h0, (raw & agree) | (exp_pk[u][15:0] & ~agree)};
`else
      exp_pk[u] = {16'h0, raw};
`endif
      prev_raw[u] = raw;
      exp_conf_total[u]++;
    end
  endtask

  task automatic check_one(input int u, input logic lat, input logic pul, input logic bsy,
                           input logic cnf, input logic [31:0] pk);
    int d;
    d = cyc - start_c[u];
    check_bit($sformatf("u%0d latch", u), lat, (d >= 0 && d <= 3));
    check_bit($sformatf("u%0d pulse", u), pul, (d >= 6 && d <= 33 && ((d - 6) % 4) < 2));
    check_bit($sformatf("u%0d busy", u), bsy, (d >= 0 && d < FRAME_LEN));
    check_bit($sformatf("u%0d confirm", u), cnf, (d == FRAME_LEN));
    check_word($sformatf("u%0d packed_out", u), pk, exp_pk[u]);
    if (lat && pul) overlap_n++;
    if (cnf) obs_conf_total[u]++;
  endtask

  task automatic check_all();
    check_one(0, if_a.latch, if_a.pulse, if_a.busy, if_a.confirm, if_a.packed_out);
    check_one(1, if_b.latch, if_b.pulse, if_b.busy, if_b.confirm, if_b.packed_out);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    case (mode)
      1: begin
        // NES controller: latch loads bit 0, each pulse rise shifts one bit.
        if (if_a.latch) cidx = 0;
        else if (if_a.pulse && !pulse_seen) cidx++;
        pulse_seen = if_a.pulse;
        line1 = (cidx < 8) ? ~btn1[cidx[2:0]] : 1'b1;
        line2 = (cidx < 8) ? ~btn2[cidx[2:0]] : 1'b1;
      end
      2: begin
        line1 = 1'($urandom_range(0, 1));
        line2 = 1'($urandom_range(0, 1));
      end
      3: begin
        line1 = (cyc >= 404) ? 1'b0 : 1'b1;
        line2 = 1'b1;
      end
      default: begin
        line1 = 1'b1;
        line2 = 1'b1;
      end
    endcase
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (!rst) begin
      cyc++;
      hist1[cyc] = line1;
      hist2[cyc] = line2;
      model_edge(0, 100);
      model_edge(1, 30);
    end
    @(negedge clk);
    check_all();
    if (if_a.latch) begin
      lat_n++;
      if (first_latch < 0) first_latch = cyc;
    end
    if (if_a.pulse) pul_n++;
    if (if_a.pulse && !pulse_prev_a) rise_n++;
    pulse_prev_a = if_a.pulse;
    if (if_a.confirm) conf_at = cyc;
    drive();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) run_cycle();
  endtask

  // Called at a negedge (or before the first edge); asynchronous reset must
  // clear every output before the next clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    cyc = 0;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    lat_n = 0; pul_n = 0; rise_n = 0; conf_at = -1; first_latch = -1;
    pulse_prev_a = 1'b0;
    cidx = 8;
    pulse_seen = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] deb_seq [5];
  logic [7:0] exp6;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; overlap_n = 0;
    exp_conf_total[0] = 0; exp_conf_total[1] = 0;
    obs_conf_total[0] = 0; obs_conf_total[1] = 0;
    mode = 0; btn1 = 8'h00; btn2 = 8'h00;
    rst = 1'b0; line1 = 1'b1; line2 = 1'b1;
    model_reset();
    #2;
    do_reset();

    // 1: lines idle high -> first frame at tick 100, confirm at 135, all zero.
    run_to(140);
    check_word("t1 first latch cycle", first_latch, 100);
    check_word("t1 latch high cycles", lat_n, 4);
    check_word("t1 pulse high cycles", pul_n, 14);
    check_word("t1 pulse rises", rise_n, 7);
    check_word("t1 confirm cycle", conf_at, 135);
    check_word("t1 packed_out", if_a.packed_out, 32'h0000_0000);

    // 2: controllers report A+Right on p1 and Up on p2.
    mode = 1; btn1 = 8'b1000_0001; btn2 = 8'h10;
    run_to(340);
    check_word("t2 packed_out", if_a.packed_out, 32'h0000_1081);
    check_word("t2 confirm cycle", conf_at, 335);
    run_to(399);
    check_word("t2 packed_out held", if_a.packed_out, 32'h0000_1081);

    // 4: p1 falls one cycle before the bit-0 sample edge of the frame at 400.
    mode = 3;
    run_to(440);
`ifdef T03_NES_DEBOUNCE_EN
    check_word("t4 packed_out", if_a.packed_out, 32'h0000_1081);
`else
    check_word("t4 packed_out", if_a.packed_out, 32'h0000_00FE);
`endif

    // 3: reset during the 4th pulse-high phase.
    mode = 2;
    for (int k = 0; k < 300 && (cyc - start_c[0]) != 18; k++) run_cycle();
    check_word("t3 reached 4th PHI", cyc - start_c[0], 18);
    check_bit("t3 pulse before reset", if_a.pulse, 1'b1);
    do_reset();
    check_word("t3 packed_out after reset", if_a.packed_out, 32'h0);
    mode = 0;
    run_to(110);
    check_word("t3 first latch after reset", first_latch, 100);

    // random lines over several frames of both pollers
    mode = 2;
    run_to(800);

    // 6: two-frame agreement behaviour on p1 bit 0.
    do_reset();
    mode = 1; btn2 = 8'h00;
    deb_seq[0] = 8'h01; deb_seq[1] = 8'h00; deb_seq[2] = 8'h00;
    deb_seq[3] = 8'h01; deb_seq[4] = 8'h01;
    for (int f = 0; f < 5; f++) begin
      btn1 = deb_seq[f];
`ifdef T03_NES_DEBOUNCE_EN
      exp6 = (f == 4) ? 8'h01 : 8'h00;
`else
      exp6 = deb_seq[f];
`endif
      run_to(100 * (f + 1) + 40);
      check_word($sformatf("t6 frame %0d p1", f), {24'h0, if_a.packed_out[7:0]}, {24'h0, exp6});
    end

    // 5: short poll period - confirm count follows the idle-only start rule.
    check_word("t5 dut_b confirm count", obs_conf_total[1], exp_conf_total[1]);
    check_word("t5 dut_a confirm count", obs_conf_total[0], exp_conf_total[0]);
    check_word("latch/pulse overlap", overlap_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
